// File: rtl/vector_sequencer.sv
// Replays a loadable vector table onto main's bus and checks its read data.
// Latency: Start edge -> DutReset cycle -> idle cycle -> vector 0 on bus, then 1 vector/cycle.
// Backpressure: none; Start and LoadEn are ignored while a replay is in progress.
module vector_sequencer #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32,
    parameter int PtrWidth  = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 LoadEn,
    input  logic [PtrWidth-1:0]  LoadPtr,
    input  logic [1:0]           LoadOp,
    input  logic [AddrWidth-1:0] LoadAddr,
    input  logic [DataWidth-1:0] LoadData,
    input  logic                 Start,
    output logic                 DutReset,
    output logic                 RD,
    output logic                 WR,
    output logic [AddrWidth-1:0] Addr,
    output logic [DataWidth-1:0] DataIn,
    input  logic [DataWidth-1:0] DataOut,
    output logic                 Busy,
    output logic                 Done,
    output logic [15:0]          ErrCount,
    output logic [PtrWidth-1:0]  FirstErrPtr,
    output logic [DataWidth-1:0] FirstErrData
);

    localparam int Depth = 1 << PtrWidth;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_END = 2'b11;

    typedef struct packed {
        logic [1:0]           op;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } vec_t;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP, S_RUN, S_DONE} state_t;

    vec_t                 vec_table [0:Depth-1];
    vec_t                 fetch;
    state_t               state_q, state_d;
    logic [PtrWidth-1:0]  ptr_q;
    logic [PtrWidth-1:0]  cur_ptr_q;
    logic                 last_q;
    logic [DataWidth-1:0] exp_q;
    logic                 err_seen_q;

    logic                 idle_like;
    logic                 start_acc;
    logic                 load_acc;
    logic                 issue;
    logic                 finish;
    logic                 dut_reset_d, rd_d, wr_d;
    logic [AddrWidth-1:0] addr_d;
    logic [DataWidth-1:0] data_in_d;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_acc = Start && idle_like;
    assign load_acc  = LoadEn && idle_like;
    assign fetch     = vec_table[ptr_q];
    // The GAP cycle already fetches entry 0 so it appears on the bus in the first RUN cycle.
    assign issue     = (state_q == S_GAP) || (state_q == S_RUN);
    assign finish    = issue && ((fetch.op == OP_END) || last_q);

    always_ff @(posedge Clk) begin
        if (load_acc) begin
            vec_table[LoadPtr] <= '{op: LoadOp, addr: LoadAddr, data: LoadData};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (Start) state_d = S_RST;
            S_RST:          state_d = S_GAP;
            S_GAP, S_RUN:   state_d = finish ? S_DONE : S_RUN;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dut_reset_d = start_acc;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        addr_d      = '0;
        data_in_d   = '0;
        if (issue && !finish) begin
            unique case (fetch.op)
                OP_WR: begin
                    wr_d      = 1'b1;
                    addr_d    = fetch.addr;
                    data_in_d = fetch.data;
                end
                OP_RD: begin
                    rd_d   = 1'b1;
                    addr_d = fetch.addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DutReset  <= 1'b0;
            RD        <= 1'b0;
            WR        <= 1'b0;
            Addr      <= '0;
            DataIn    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ptr_q     <= '0;
            cur_ptr_q <= '0;
            last_q    <= 1'b0;
            exp_q     <= '0;
        end else begin
            DutReset <= dut_reset_d;
            RD       <= rd_d;
            WR       <= wr_d;
            Addr     <= addr_d;
            DataIn   <= data_in_d;
            Busy     <= (state_d == S_RST) || (state_d == S_GAP) || (state_d == S_RUN);
            Done     <= (state_d == S_DONE);
            if (start_acc) begin
                ptr_q  <= '0;
                last_q <= 1'b0;
            end else if (issue && !finish) begin
                exp_q     <= fetch.data;
                cur_ptr_q <= ptr_q;
                // Hold the pointer at the top entry; the next edge then terminates like END.
                if (ptr_q == {PtrWidth{1'b1}}) begin
                    last_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ErrCount     <= '0;
            FirstErrPtr  <= '0;
            FirstErrData <= '0;
            err_seen_q   <= 1'b0;
        end else if (start_acc) begin
            ErrCount     <= '0;
            FirstErrPtr  <= '0;
            FirstErrData <= '0;
            err_seen_q   <= 1'b0;
        end else if (RD && (DataOut != exp_q)) begin
            if (ErrCount != 16'hFFFF) begin
                ErrCount <= ErrCount + 16'd1;
            end
            if (!err_seen_q) begin
                err_seen_q   <= 1'b1;
                FirstErrPtr  <= cur_ptr_q;
                FirstErrData <= DataOut;
            end
        end
    end

endmodule
